// File: rtl/wb_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: bus widths,
// FSM state encoding, the per-master request payload and the grant helper.
package wb_arbiter_pkg;

  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_AW = 31;
  localparam int unsigned WB_SW = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN  = 2'b01,
    ARB_ERR  = 2'b10
  } arb_state_e;

  // Everything a master presents toward the slave port.
  typedef struct packed {
    logic [WB_DW-1:0] dat;
    logic [WB_AW-1:0] adr;
    logic [WB_SW-1:0] sel;
    logic             we;
    logic             cyc;
    logic             stb;
  } wb_req_t;

  // Round-robin pick: on contention the master that did not own last wins.
  function automatic logic pick_owner(input logic cyc0, input logic cyc1, input logic last);
    if (cyc0 && cyc1) begin
      return ~last;
    end
    return cyc1;
  endfunction

endpackage

// File: rtl/wb_bus_watchdog.sv
// Bus watchdog: counts strobe cycles without acknowledge and flags expiry
// when a strobe has waited TIMEOUT cycles.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   clr    : clear counter (arbiter not in an owned cycle)
//   stb    : owner strobe active this cycle
//   ack    : slave acknowledge this cycle
//   expire : counter at TIMEOUT-1 with strobe and no ack (combinational)
module wb_bus_watchdog #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic stb,
  input  logic ack,
  output logic expire
);

  if (TIMEOUT < 2 || TIMEOUT > 255 || (64'd1 << TW) <= 64'(TIMEOUT)) begin : g_bad_param
    $error("wb_bus_watchdog: illegal TIMEOUT/TW combination");
  end

  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] wd;

  // Counter holds at WD_LAST instead of wrapping; the arbiter clears it via ERR.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr || ack) begin
      wd <= '0;
    end else if (stb && (wd != WD_LAST)) begin
      wd <= wd + TW'(1);
    end
  end

  assign expire = stb && !ack && !clr && (wd == WD_LAST);

endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with bus watchdog.
// Master 0 = instruction fetch, master 1 = data port. The owner keeps the
// bus until it drops cyc; an unacknowledged strobe is terminated with err.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   wbm_<m>_*_i           : master m request (dat, adr, sel, we, cyc, stb)
//   wbm_<m>_dat_o         : read data (wbs_dat_i to both masters)
//   wbm_<m>_ack_o/err_o   : ack / watchdog error, owner only
//   wbs_*_o               : muxed request toward the interconnect
//   wbs_dat_i, wbs_ack_i  : slave read data and acknowledge
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,

  input  logic [WB_DW-1:0] wbm_0_dat_i,
  input  logic [WB_AW-1:0] wbm_0_adr_i,
  input  logic [WB_SW-1:0] wbm_0_sel_i,
  input  logic             wbm_0_we_i,
  input  logic             wbm_0_cyc_i,
  input  logic             wbm_0_stb_i,
  output logic [WB_DW-1:0] wbm_0_dat_o,
  output logic             wbm_0_ack_o,
  output logic             wbm_0_err_o,

  input  logic [WB_DW-1:0] wbm_1_dat_i,
  input  logic [WB_AW-1:0] wbm_1_adr_i,
  input  logic [WB_SW-1:0] wbm_1_sel_i,
  input  logic             wbm_1_we_i,
  input  logic             wbm_1_cyc_i,
  input  logic             wbm_1_stb_i,
  output logic [WB_DW-1:0] wbm_1_dat_o,
  output logic             wbm_1_ack_o,
  output logic             wbm_1_err_o,

  output logic [WB_DW-1:0] wbs_dat_o,
  output logic [WB_AW-1:0] wbs_adr_o,
  output logic [WB_SW-1:0] wbs_sel_o,
  output logic             wbs_we_o,
  output logic             wbs_cyc_o,
  output logic             wbs_stb_o,
  input  logic [WB_DW-1:0] wbs_dat_i,
  input  logic             wbs_ack_i
);

  arb_state_e state_q, state_d;
  logic       last_q, last_d;   // previous owner; also the current owner outside IDLE
  wb_req_t    req [2];
  wb_req_t    own;
  logic [1:0] ack_c, err_c;
  logic       wd_clr, wd_stb, wd_expire;

  assign req[0] = '{dat: wbm_0_dat_i, adr: wbm_0_adr_i, sel: wbm_0_sel_i,
                    we: wbm_0_we_i, cyc: wbm_0_cyc_i, stb: wbm_0_stb_i};
  assign req[1] = '{dat: wbm_1_dat_i, adr: wbm_1_adr_i, sel: wbm_1_sel_i,
                    we: wbm_1_we_i, cyc: wbm_1_cyc_i, stb: wbm_1_stb_i};
  assign own    = req[last_q];

  // Read data is broadcast; only ack/err qualify it.
  assign wbm_0_dat_o = wbs_dat_i;
  assign wbm_1_dat_o = wbs_dat_i;
  assign wbm_0_ack_o = ack_c[0];
  assign wbm_1_ack_o = ack_c[1];
  assign wbm_0_err_o = err_c[0];
  assign wbm_1_err_o = err_c[1];

  // Watchdog only runs while a strobe is pending in an owned cycle.
  assign wd_clr = (state_q != ARB_OWN);
  assign wd_stb = (state_q == ARB_OWN) && own.stb;

  wb_bus_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (wd_clr),
    .stb    (wd_stb),
    .ack    (wbs_ack_i),
    .expire (wd_expire)
  );

  // State and owner registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state, grant and bus mux.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wbs_dat_o = '0;
    wbs_adr_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    ack_c     = 2'b00;
    err_c     = 2'b00;

    unique case (state_q)
      ARB_IDLE: begin
        if (wbm_0_cyc_i || wbm_1_cyc_i) begin
          state_d = ARB_OWN;
          last_d  = pick_owner(wbm_0_cyc_i, wbm_1_cyc_i, last_q);
        end
      end

      ARB_OWN: begin
        wbs_dat_o     = own.dat;
        wbs_adr_o     = own.adr;
        wbs_sel_o     = own.sel;
        wbs_we_o      = own.we;
        wbs_cyc_o     = own.cyc;
        wbs_stb_o     = own.stb;
        ack_c[last_q] = wbs_ack_i;
        // Release takes priority; a dropped cyc with pending expiry is not an error.
        if (!own.cyc) begin
          state_d = ARB_IDLE;
        end else if (wd_expire) begin
          state_d = ARB_ERR;
        end
      end

      ARB_ERR: begin
        wbs_dat_o     = own.dat;
        wbs_adr_o     = own.adr;
        wbs_sel_o     = own.sel;
        wbs_we_o      = own.we;
        wbs_cyc_o     = own.cyc;
        err_c[last_q] = 1'b1;
        state_d       = ARB_OWN;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: grant latency, round-robin, isolation of
// the stalled master, watchdog error, ack-on-expiry and mid-cycle reset.
module tb_wb_arbiter;

  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned TW      = 3;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] wbm_0_dat_i, wbm_1_dat_i;
  logic [30:0] wbm_0_adr_i, wbm_1_adr_i;
  logic [1:0]  wbm_0_sel_i, wbm_1_sel_i;
  logic        wbm_0_we_i, wbm_0_cyc_i, wbm_0_stb_i;
  logic        wbm_1_we_i, wbm_1_cyc_i, wbm_1_stb_i;
  logic [31:0] wbm_0_dat_o, wbm_1_dat_o;
  logic        wbm_0_ack_o, wbm_0_err_o, wbm_1_ack_o, wbm_1_err_o;
  logic [31:0] wbs_dat_o, wbs_dat_i;
  logic [30:0] wbs_adr_o;
  logic [1:0]  wbs_sel_o;
  logic        wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_ack_i;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .wbm_0_dat_i (wbm_0_dat_i),
    .wbm_0_adr_i (wbm_0_adr_i),
    .wbm_0_sel_i (wbm_0_sel_i),
    .wbm_0_we_i  (wbm_0_we_i),
    .wbm_0_cyc_i (wbm_0_cyc_i),
    .wbm_0_stb_i (wbm_0_stb_i),
    .wbm_0_dat_o (wbm_0_dat_o),
    .wbm_0_ack_o (wbm_0_ack_o),
    .wbm_0_err_o (wbm_0_err_o),
    .wbm_1_dat_i (wbm_1_dat_i),
    .wbm_1_adr_i (wbm_1_adr_i),
    .wbm_1_sel_i (wbm_1_sel_i),
    .wbm_1_we_i  (wbm_1_we_i),
    .wbm_1_cyc_i (wbm_1_cyc_i),
    .wbm_1_stb_i (wbm_1_stb_i),
    .wbm_1_dat_o (wbm_1_dat_o),
    .wbm_1_ack_o (wbm_1_ack_o),
    .wbm_1_err_o (wbm_1_err_o),
    .wbs_dat_o   (wbs_dat_o),
    .wbs_adr_o   (wbs_adr_o),
    .wbs_sel_o   (wbs_sel_o),
    .wbs_we_o    (wbs_we_o),
    .wbs_cyc_o   (wbs_cyc_o),
    .wbs_stb_o   (wbs_stb_o),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_i   (wbs_ack_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic cyc, input logic stb, input logic [30:0] adr,
                       input logic [31:0] dat, input logic we, input logic [1:0] sel);
    if (m == 0) begin
      wbm_0_cyc_i = cyc; wbm_0_stb_i = stb; wbm_0_adr_i = adr;
      wbm_0_dat_i = dat; wbm_0_we_i  = we;  wbm_0_sel_i = sel;
    end else begin
      wbm_1_cyc_i = cyc; wbm_1_stb_i = stb; wbm_1_adr_i = adr;
      wbm_1_dat_i = dat; wbm_1_we_i  = we;  wbm_1_sel_i = sel;
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " cyc"},  32'(wbs_cyc_o),   32'd0);
    check({tag, " stb"},  32'(wbs_stb_o),   32'd0);
    check({tag, " adr"},  32'(wbs_adr_o),   32'd0);
    check({tag, " ack0"}, 32'(wbm_0_ack_o), 32'd0);
    check({tag, " ack1"}, 32'(wbm_1_ack_o), 32'd0);
    check({tag, " err0"}, 32'(wbm_0_err_o), 32'd0);
    check({tag, " err1"}, 32'(wbm_1_err_o), 32'd0);
  endtask

  initial begin
    rst_i = 1'b1;
    wbs_ack_i = 1'b0;
    wbs_dat_i = 32'h1234_5678;
    set_m(0, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0, 2'b00);
    set_m(1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0, 2'b00);

    // Reset state
    tick(); tick();
    #1;
    check_quiet("rst");
    check("rst dat0", wbm_0_dat_o, 32'h1234_5678);
    check("rst dat1", wbm_1_dat_o, 32'h1234_5678);

    // Master 0 read of 0x100, ack two cycles after stb
    tick();
    rst_i = 1'b0;
    set_m(0, 1'b1, 1'b1, 31'h80, 32'h0, 1'b0, 2'b11);
    #1 check("rd idle stb", 32'(wbs_stb_o), 32'd0);
    tick();
    #1 check("rd grant stb", 32'(wbs_stb_o), 32'd1);
    check("rd grant adr", 32'(wbs_adr_o), 32'h80);
    check("rd wait1 ack0", 32'(wbm_0_ack_o), 32'd0);
    tick();
    #1 check("rd wait2 ack0", 32'(wbm_0_ack_o), 32'd0);
    tick();
    wbs_ack_i = 1'b1; wbs_dat_i = 32'hCAFE_F00D;
    #1 check("rd ack0", 32'(wbm_0_ack_o), 32'd1);
    check("rd dat0", wbm_0_dat_o, 32'hCAFE_F00D);
    check("rd ack1", 32'(wbm_1_ack_o), 32'd0);
    check("rd err0", 32'(wbm_0_err_o), 32'd0);
    tick();
    wbs_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0, 2'b00);
    #1 check("rd after ack0", 32'(wbm_0_ack_o), 32'd0);
    check("rd release cyc", 32'(wbs_cyc_o), 32'd0);

    // Contention from reset: master 0 first, then 1, then 0 again
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    set_m(0, 1'b1, 1'b1, 31'h111, 32'h0, 1'b0, 2'b11);
    set_m(1, 1'b1, 1'b1, 31'h222, 32'h0, 1'b0, 2'b11);
    tick();
    wbs_ack_i = 1'b1;
    #1 check("rr1 adr", 32'(wbs_adr_o), 32'h111);
    check("rr1 ack0", 32'(wbm_0_ack_o), 32'd1);
    check("rr1 ack1", 32'(wbm_1_ack_o), 32'd0);
    tick();
    wbs_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 31'h111, 32'h0, 1'b0, 2'b11);
    tick();
    #1 check("rr turnaround cyc", 32'(wbs_cyc_o), 32'd0);
    check("rr turnaround adr", 32'(wbs_adr_o), 32'd0);
    tick();
    wbs_ack_i = 1'b1;
    #1 check("rr2 adr", 32'(wbs_adr_o), 32'h222);
    check("rr2 ack1", 32'(wbm_1_ack_o), 32'd1);
    check("rr2 ack0", 32'(wbm_0_ack_o), 32'd0);
    tick();
    wbs_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 31'h222, 32'h0, 1'b0, 2'b11);
    tick();
    set_m(0, 1'b1, 1'b1, 31'h111, 32'h0, 1'b0, 2'b11);
    set_m(1, 1'b1, 1'b1, 31'h222, 32'h0, 1'b0, 2'b11);
    tick();
    #1 check("rr3 adr", 32'(wbs_adr_o), 32'h111);
    tick();
    set_m(0, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0, 2'b00);
    set_m(1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0, 2'b00);

    // Master 1 write while master 0 stalls
    tick();
    set_m(1, 1'b1, 1'b1, 31'h1000, 32'hDEAD_BEEF, 1'b1, 2'b11);
    tick();
    set_m(0, 1'b1, 1'b1, 31'h555, 32'h1111_1111, 1'b0, 2'b01);
    #1 check("wr adr", 32'(wbs_adr_o), 32'h1000);
    check("wr dat", wbs_dat_o, 32'hDEAD_BEEF);
    check("wr we", 32'(wbs_we_o), 32'd1);
    check("wr sel", 32'(wbs_sel_o), 32'd3);
    tick();
    wbs_ack_i = 1'b1;
    #1 check("wr ack1", 32'(wbm_1_ack_o), 32'd1);
    check("wr stall ack0", 32'(wbm_0_ack_o), 32'd0);
    check("wr still adr", 32'(wbs_adr_o), 32'h1000);
    tick();
    wbs_ack_i = 1'b0;
    set_m(1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0, 2'b00);
    tick();
    wbs_ack_i = 1'b1;
    #1 check("wr idle ack0", 32'(wbm_0_ack_o), 32'd0);
    tick();
    #1 check("m0 after wr adr", 32'(wbs_adr_o), 32'h555);
    check("m0 after wr ack0", 32'(wbm_0_ack_o), 32'd1);
    check("m0 after wr sel", 32'(wbs_sel_o), 32'd1);
    tick();
    wbs_ack_i = 1'b0;
    set_m(0, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0, 2'b00);
    tick();

    // Watchdog: no ack, err 4 cycles after stb, then retry acked on cycle 2
    set_m(0, 1'b1, 1'b1, 31'h7FF, 32'h0, 1'b0, 2'b11);
    tick();
    #1 check("wd c1 stb", 32'(wbs_stb_o), 32'd1);
    tick(); tick(); tick();
    #1 check("wd c4 err0", 32'(wbm_0_err_o), 32'd0);
    check("wd c4 stb", 32'(wbs_stb_o), 32'd1);
    tick();
    wbs_ack_i = 1'b1;
    #1 check("wd err0", 32'(wbm_0_err_o), 32'd1);
    check("wd err stb", 32'(wbs_stb_o), 32'd0);
    check("wd err cyc", 32'(wbs_cyc_o), 32'd1);
    check("wd err err1", 32'(wbm_1_err_o), 32'd0);
    check("wd err ack dropped", 32'(wbm_0_ack_o), 32'd0);
    tick();
    wbs_ack_i = 1'b0;
    #1 check("wd retry err0", 32'(wbm_0_err_o), 32'd0);
    check("wd retry stb", 32'(wbs_stb_o), 32'd1);
    tick();
    wbs_ack_i = 1'b1;
    #1 check("wd retry ack0", 32'(wbm_0_ack_o), 32'd1);
    check("wd retry no err", 32'(wbm_0_err_o), 32'd0);

    // Ack on the exact expiry cycle wins
    tick();
    wbs_ack_i = 1'b0;
    tick(); tick();
    #1 check("exp c3 ack0", 32'(wbm_0_ack_o), 32'd0);
    tick();
    wbs_ack_i = 1'b1;
    #1 check("exp ack0", 32'(wbm_0_ack_o), 32'd1);
    check("exp err0", 32'(wbm_0_err_o), 32'd0);
    tick();
    wbs_ack_i = 1'b0;
    #1 check("exp after err0", 32'(wbm_0_err_o), 32'd0);
    check("exp after stb", 32'(wbs_stb_o), 32'd1);
    set_m(0, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0, 2'b00);
    tick();

    // Reset mid-owned cycle, then normal grant latency
    set_m(1, 1'b1, 1'b1, 31'h3AB, 32'h0, 1'b0, 2'b11);
    tick();
    #1 check("mr own stb", 32'(wbs_stb_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    wbs_ack_i = 1'b1;
    #1 check_quiet("mr post");
    tick();
    wbs_ack_i = 1'b0;
    #1 check("mr regrant stb", 32'(wbs_stb_o), 32'd1);
    check("mr regrant adr", 32'(wbs_adr_o), 32'h3AB);
    check("mr regrant err1", 32'(wbm_1_err_o), 32'd0);
    set_m(1, 1'b0, 1'b0, 31'h0, 32'h0, 1'b0, 2'b00);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
